// File: rtl/axi_arbiter2_if.sv
// AXI4 channel bundle: AW, W, B, AR and R with valid/ready handshakes.
// Latency: none, this is wiring only.
// Backpressure: carried by each channel's ready signal.
// Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH (one user width for every channel).
// Modports: master (drives requests, receives responses); slave (the reverse).
interface axi_channel #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
);
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic [USER_WIDTH-1:0]   aw_user;
   logic                    aw_valid;
   logic                    aw_ready;

   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic [USER_WIDTH-1:0]   w_user;
   logic                    w_valid;
   logic                    w_ready;

   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;
   logic [USER_WIDTH-1:0]   b_user;
   logic                    b_valid;
   logic                    b_ready;

   logic [ID_WIDTH-1:0]     ar_id;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic [USER_WIDTH-1:0]   ar_user;
   logic                    ar_valid;
   logic                    ar_ready;

   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_last;
   logic [USER_WIDTH-1:0]   r_user;
   logic                    r_valid;
   logic                    r_ready;

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/axi_arbiter2.sv
// Two-master to one-slave AXI arbiter: round-robin AW and AR, W steered in AW-grant order, B/R routed by ID MSB.
// Latency: zero-cycle combinational pass-through on every channel; W of a burst starts the cycle after its AW handshake.
// Backpressure: slave ready goes only to the selected master; AW stalls while W_FIFO_DEPTH bursts await their last W beat.
// Ports: clk, rst (async, active high); master0/master1 upstream (slave modport); slave downstream (master modport).
module axi_arbiter2 #(
   parameter int W_FIFO_DEPTH = 4
) (
   input logic        clk,
   input logic        rst,
   axi_channel.slave  master0,
   axi_channel.slave  master1,
   axi_channel.master slave
);
   localparam int IW = master0.ID_WIDTH;
   localparam int PW = $clog2(W_FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

   // Elaboration-time configuration checks.
   if (slave.ID_WIDTH != master0.ID_WIDTH + 1) begin : g_bad_id
      $fatal(1, "axi_arbiter2: slave ID width must be master ID width + 1");
   end
   if (master0.ID_WIDTH != master1.ID_WIDTH || master0.ADDR_WIDTH != master1.ADDR_WIDTH ||
       master0.DATA_WIDTH != master1.DATA_WIDTH || master0.USER_WIDTH != master1.USER_WIDTH) begin : g_bad_masters
      $fatal(1, "axi_arbiter2: master0 and master1 parameters differ");
   end
   if (master0.ADDR_WIDTH != slave.ADDR_WIDTH || master0.DATA_WIDTH != slave.DATA_WIDTH ||
       master0.USER_WIDTH != slave.USER_WIDTH) begin : g_bad_slave
      $fatal(1, "axi_arbiter2: address, data or user width differs from slave");
   end
   if (W_FIFO_DEPTH < 2 || (W_FIFO_DEPTH & (W_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "axi_arbiter2: W_FIFO_DEPTH must be a power of two and at least 2");
   end

   logic                    aw_prio, aw_lock, aw_lock_src;
   logic                    ar_prio, ar_lock, ar_lock_src;
   logic [W_FIFO_DEPTH-1:0] wf_src;
   logic [PW-1:0]           wf_rd, wf_wr;
   logic [PW:0]             wf_cnt;

   logic aw_src, aw_req, aw_hs, aw_stall;
   logic ar_src, ar_req, ar_hs, ar_stall;
   logic wf_full, wf_empty, wf_head, w_pop;
   logic aw_g0, aw_g1, ar_g0, ar_g1;
   logic b_sel, r_sel;

   // Count never exceeds the depth, so its MSB alone flags full.
   assign wf_full  = wf_cnt[PW];
   assign wf_empty = (wf_cnt == '0);
   assign wf_head  = wf_src[wf_rd];

   // ---------------- AW arbitration ----------------
   always_comb begin
      aw_src = 1'b0;
      if (aw_lock)
         aw_src = aw_lock_src;
      else if (master0.aw_valid && master1.aw_valid)
         aw_src = aw_prio;
      else
         aw_src = master1.aw_valid;
   end

   assign aw_req   = aw_src ? master1.aw_valid : master0.aw_valid;
   assign aw_hs    = slave.aw_valid && slave.aw_ready;
   assign aw_stall = slave.aw_valid && !slave.aw_ready;

   // Grant terms are built without the master's own valid so its ready only
   // depends on its valid through the downstream ready.
   assign aw_g0 = aw_lock ? !aw_lock_src : (!master1.aw_valid || !aw_prio);
   assign aw_g1 = aw_lock ?  aw_lock_src : (!master0.aw_valid ||  aw_prio);

   assign slave.aw_valid   = !rst && aw_req && !wf_full;
   assign master0.aw_ready = !rst && aw_g0 && !wf_full && slave.aw_ready;
   assign master1.aw_ready = !rst && aw_g1 && !wf_full && slave.aw_ready;

   assign slave.aw_id    = aw_src ? {1'b1, master1.aw_id} : {1'b0, master0.aw_id};
   assign slave.aw_addr  = aw_src ? master1.aw_addr  : master0.aw_addr;
   assign slave.aw_len   = aw_src ? master1.aw_len   : master0.aw_len;
   assign slave.aw_size  = aw_src ? master1.aw_size  : master0.aw_size;
   assign slave.aw_burst = aw_src ? master1.aw_burst : master0.aw_burst;
   assign slave.aw_user  = aw_src ? master1.aw_user  : master0.aw_user;

   // ---------------- W steering ----------------
   assign slave.w_valid   = !rst && !wf_empty && (wf_head ? master1.w_valid : master0.w_valid);
   assign master0.w_ready = !rst && !wf_empty && !wf_head && slave.w_ready;
   assign master1.w_ready = !rst && !wf_empty &&  wf_head && slave.w_ready;
   assign slave.w_data    = wf_head ? master1.w_data : master0.w_data;
   assign slave.w_strb    = wf_head ? master1.w_strb : master0.w_strb;
   assign slave.w_last    = wf_head ? master1.w_last : master0.w_last;
   assign slave.w_user    = wf_head ? master1.w_user : master0.w_user;
   assign w_pop           = slave.w_valid && slave.w_ready && slave.w_last;

   // ---------------- B routing ----------------
   assign b_sel           = slave.b_id[IW];
   assign master0.b_valid = slave.b_valid && !b_sel;
   assign master1.b_valid = slave.b_valid &&  b_sel;
   assign master0.b_id    = slave.b_id[IW-1:0];
   assign master1.b_id    = slave.b_id[IW-1:0];
   assign master0.b_resp  = slave.b_resp;
   assign master1.b_resp  = slave.b_resp;
   assign master0.b_user  = slave.b_user;
   assign master1.b_user  = slave.b_user;
   assign slave.b_ready   = b_sel ? master1.b_ready : master0.b_ready;

   // ---------------- AR arbitration ----------------
   always_comb begin
      ar_src = 1'b0;
      if (ar_lock)
         ar_src = ar_lock_src;
      else if (master0.ar_valid && master1.ar_valid)
         ar_src = ar_prio;
      else
         ar_src = master1.ar_valid;
   end

   assign ar_req   = ar_src ? master1.ar_valid : master0.ar_valid;
   assign ar_hs    = slave.ar_valid && slave.ar_ready;
   assign ar_stall = slave.ar_valid && !slave.ar_ready;
   assign ar_g0    = ar_lock ? !ar_lock_src : (!master1.ar_valid || !ar_prio);
   assign ar_g1    = ar_lock ?  ar_lock_src : (!master0.ar_valid ||  ar_prio);

   assign slave.ar_valid   = !rst && ar_req;
   assign master0.ar_ready = !rst && ar_g0 && slave.ar_ready;
   assign master1.ar_ready = !rst && ar_g1 && slave.ar_ready;

   assign slave.ar_id    = ar_src ? {1'b1, master1.ar_id} : {1'b0, master0.ar_id};
   assign slave.ar_addr  = ar_src ? master1.ar_addr  : master0.ar_addr;
   assign slave.ar_len   = ar_src ? master1.ar_len   : master0.ar_len;
   assign slave.ar_size  = ar_src ? master1.ar_size  : master0.ar_size;
   assign slave.ar_burst = ar_src ? master1.ar_burst : master0.ar_burst;
   assign slave.ar_user  = ar_src ? master1.ar_user  : master0.ar_user;

   // ---------------- R routing ----------------
   assign r_sel           = slave.r_id[IW];
   assign master0.r_valid = slave.r_valid && !r_sel;
   assign master1.r_valid = slave.r_valid &&  r_sel;
   assign master0.r_id    = slave.r_id[IW-1:0];
   assign master1.r_id    = slave.r_id[IW-1:0];
   assign master0.r_data  = slave.r_data;
   assign master1.r_data  = slave.r_data;
   assign master0.r_resp  = slave.r_resp;
   assign master1.r_resp  = slave.r_resp;
   assign master0.r_last  = slave.r_last;
   assign master1.r_last  = slave.r_last;
   assign master0.r_user  = slave.r_user;
   assign master1.r_user  = slave.r_user;
   assign slave.r_ready   = r_sel ? master1.r_ready : master0.r_ready;

   // ---------------- State ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_prio     <= 1'b0;
         aw_lock     <= 1'b0;
         aw_lock_src <= 1'b0;
         wf_src      <= '0;
         wf_rd       <= '0;
         wf_wr       <= '0;
         wf_cnt      <= '0;
      end else begin
         // Hold the winner while the slave stalls so the AW offer stays stable.
         if (aw_stall) begin
            aw_lock     <= 1'b1;
            aw_lock_src <= aw_src;
         end else if (aw_hs) begin
            aw_lock <= 1'b0;
         end
         if (aw_hs) begin
            aw_prio        <= ~aw_src;
            wf_src[wf_wr]  <= aw_src;
            wf_wr          <= wf_wr + PTR_ONE;
         end
         if (w_pop)
            wf_rd <= wf_rd + PTR_ONE;
         if (aw_hs && !w_pop)
            wf_cnt <= wf_cnt + CNT_ONE;
         else if (!aw_hs && w_pop)
            wf_cnt <= wf_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_prio     <= 1'b0;
         ar_lock     <= 1'b0;
         ar_lock_src <= 1'b0;
      end else begin
         if (ar_stall) begin
            ar_lock     <= 1'b1;
            ar_lock_src <= ar_src;
         end else if (ar_hs) begin
            ar_lock <= 1'b0;
         end
         if (ar_hs)
            ar_prio <= ~ar_src;
      end
   end
endmodule

// File: tb/tb_axi_arbiter2.sv
// Directed bench for axi_arbiter2: contention, FIFO full, lock, single master, reads, async reset.
// Latency: checks are taken 1 time unit after each falling edge, inputs driven at the falling edge.
// Backpressure: slave ready/master ready stimulus is scripted per step.
module tb_axi_arbiter2;
   logic clk;
   logic rst;
   int   total;
   int   passed;
   int   failed;
   int   k;

   axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(2)) m0_if ();
   axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(2)) m1_if ();
   axi_channel #(.ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(2)) s_if ();

   axi_arbiter2 #(.W_FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .master0 (m0_if),
      .master1 (m1_if),
      .slave   (s_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      assert (obs === want) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic idle();
      m0_if.aw_valid = 0; m0_if.aw_id = 0; m0_if.aw_addr = 0; m0_if.aw_len = 0;
      m0_if.aw_size = 0; m0_if.aw_burst = 0; m0_if.aw_user = 0;
      m0_if.w_valid = 0; m0_if.w_data = 0; m0_if.w_strb = 0; m0_if.w_last = 0; m0_if.w_user = 0;
      m0_if.b_ready = 0; m0_if.r_ready = 0;
      m0_if.ar_valid = 0; m0_if.ar_id = 0; m0_if.ar_addr = 0; m0_if.ar_len = 0;
      m0_if.ar_size = 0; m0_if.ar_burst = 0; m0_if.ar_user = 0;
      m1_if.aw_valid = 0; m1_if.aw_id = 0; m1_if.aw_addr = 0; m1_if.aw_len = 0;
      m1_if.aw_size = 0; m1_if.aw_burst = 0; m1_if.aw_user = 0;
      m1_if.w_valid = 0; m1_if.w_data = 0; m1_if.w_strb = 0; m1_if.w_last = 0; m1_if.w_user = 0;
      m1_if.b_ready = 0; m1_if.r_ready = 0;
      m1_if.ar_valid = 0; m1_if.ar_id = 0; m1_if.ar_addr = 0; m1_if.ar_len = 0;
      m1_if.ar_size = 0; m1_if.ar_burst = 0; m1_if.ar_user = 0;
      s_if.aw_ready = 0; s_if.w_ready = 0; s_if.ar_ready = 0;
      s_if.b_valid = 0; s_if.b_id = 0; s_if.b_resp = 0; s_if.b_user = 0;
      s_if.r_valid = 0; s_if.r_id = 0; s_if.r_data = 0; s_if.r_resp = 0; s_if.r_last = 0; s_if.r_user = 0;
   endtask

   initial begin
      total = 0; passed = 0; failed = 0;
      idle();
      rst = 1'b1;

      // ---- Reset state ----
      repeat (2) @(negedge clk);
      m0_if.w_valid = 1;
      #1;
      chk("rst_aw_valid", s_if.aw_valid, 0);
      chk("rst_ar_valid", s_if.ar_valid, 0);
      chk("rst_w_valid", s_if.w_valid, 0);
      chk("rst_m0_b_valid", m0_if.b_valid, 0);
      chk("rst_m1_r_valid", m1_if.r_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      m0_if.w_valid = 0;

      // ---- Contention: grants alternate 0,1,0,1 and fill the W FIFO ----
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            m0_if.aw_valid = 1; m0_if.aw_id = 4'h1; m0_if.aw_addr = 32'hA0;
            m1_if.aw_valid = 1; m1_if.aw_id = 4'h2; m1_if.aw_addr = 32'hB0;
            s_if.aw_ready = 1; s_if.w_ready = 1;
         end
         #1;
         chk("cont_aw_id", s_if.aw_id, (i % 2) ? 5'h12 : 5'h01);
         chk("cont_m0_ready", m0_if.aw_ready, (i % 2) ? 1'b0 : 1'b1);
         chk("cont_m1_ready", m1_if.aw_ready, (i % 2) ? 1'b1 : 1'b0);
      end
      // 5th AW from master1 with FIFO full
      @(negedge clk);
      m0_if.aw_valid = 0; m1_if.aw_addr = 32'hB4;
      #1;
      chk("full_aw_valid", s_if.aw_valid, 0);
      chk("full_m1_ready", m1_if.aw_ready, 0);
      chk("full_w_idle", s_if.w_valid, 0);
      // head burst is master0's; pop at full must not let the AW through
      @(negedge clk);
      m0_if.w_valid = 1; m0_if.w_data = 32'hD0; m0_if.w_last = 1;
      #1;
      chk("w0_valid", s_if.w_valid, 1);
      chk("w0_data", s_if.w_data, 32'hD0);
      chk("w0_m0_ready", m0_if.w_ready, 1);
      chk("w0_m1_ready", m1_if.w_ready, 0);
      chk("full_pop_stall", s_if.aw_valid, 0);
      // 5th AW accepted; head now master1
      @(negedge clk);
      m0_if.w_valid = 0;
      m1_if.w_valid = 1; m1_if.w_data = 32'hD1; m1_if.w_last = 1;
      #1;
      chk("aw5_valid", s_if.aw_valid, 1);
      chk("aw5_addr", s_if.aw_addr, 32'hB4);
      chk("aw5_id", s_if.aw_id, 5'h12);
      chk("aw5_m1_ready", m1_if.aw_ready, 1);
      chk("w1_data", s_if.w_data, 32'hD1);
      chk("w1_m1_ready", m1_if.w_ready, 1);
      @(negedge clk);
      m1_if.aw_valid = 0;
      #1;
      chk("w2_wait_valid", s_if.w_valid, 0);
      chk("w2_wait_m1_ready", m1_if.w_ready, 0);
      @(negedge clk);
      m0_if.w_valid = 1; m0_if.w_data = 32'hD2;
      #1;
      chk("w2_data", s_if.w_data, 32'hD2);
      chk("w2_m0_ready", m0_if.w_ready, 1);
      @(negedge clk);
      m0_if.w_valid = 0; m1_if.w_data = 32'hD3;
      #1;
      chk("w3_data", s_if.w_data, 32'hD3);
      chk("w3_m1_ready", m1_if.w_ready, 1);
      @(negedge clk);
      m1_if.w_data = 32'hD5;
      #1;
      chk("w5_valid", s_if.w_valid, 1);
      chk("w5_data", s_if.w_data, 32'hD5);
      @(negedge clk);
      m0_if.w_valid = 1;
      #1;
      chk("drained_valid", s_if.w_valid, 0);
      chk("drained_m0_ready", m0_if.w_ready, 0);
      chk("drained_m1_ready", m1_if.w_ready, 0);

      // ---- Lock: master1 stalled 3 cycles, master0 arrives meanwhile ----
      @(negedge clk);
      idle();
      s_if.w_ready = 1;
      m1_if.aw_valid = 1; m1_if.aw_id = 4'h7; m1_if.aw_addr = 32'hC0;
      #1;
      chk("lock_valid", s_if.aw_valid, 1);
      chk("lock_id0", s_if.aw_id, 5'h17);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         m0_if.aw_valid = 1; m0_if.aw_id = 4'h5; m0_if.aw_addr = 32'hE0;
         #1;
         chk("lock_addr", s_if.aw_addr, 32'hC0);
         chk("lock_id", s_if.aw_id, 5'h17);
         chk("lock_m0_ready", m0_if.aw_ready, 0);
      end
      @(negedge clk);
      s_if.aw_ready = 1;
      #1;
      chk("lock_hs_addr", s_if.aw_addr, 32'hC0);
      chk("lock_hs_m1_ready", m1_if.aw_ready, 1);
      chk("lock_hs_m0_ready", m0_if.aw_ready, 0);
      @(negedge clk);
      m1_if.aw_valid = 0;
      #1;
      chk("after_lock_id", s_if.aw_id, 5'h05);
      chk("after_lock_addr", s_if.aw_addr, 32'hE0);
      chk("after_lock_m0_ready", m0_if.aw_ready, 1);
      @(negedge clk);
      m0_if.aw_valid = 0;
      m0_if.w_valid = 1; m0_if.w_data = 32'hD8; m0_if.w_last = 1;
      m1_if.w_valid = 1; m1_if.w_data = 32'hD7; m1_if.w_last = 1;
      #1;
      chk("lock_w_first", s_if.w_data, 32'hD7);
      chk("lock_w_m0_wait", m0_if.w_ready, 0);
      @(negedge clk);
      m1_if.w_valid = 0;
      #1;
      chk("lock_w_second", s_if.w_data, 32'hD8);
      chk("lock_w_m0_ready", m0_if.w_ready, 1);
      @(negedge clk);
      m0_if.w_valid = 0;
      s_if.b_valid = 1; s_if.b_id = 5'h17; s_if.b_resp = 2'd2;
      m0_if.b_ready = 1; m1_if.b_ready = 0;
      #1;
      chk("b1_m1_valid", m1_if.b_valid, 1);
      chk("b1_m0_valid", m0_if.b_valid, 0);
      chk("b1_m1_id", m1_if.b_id, 4'h7);
      chk("b1_m0_resp_fanout", m0_if.b_resp, 2'd2);
      chk("b1_backpressure", s_if.b_ready, 0);
      @(negedge clk);
      m1_if.b_ready = 1;
      #1;
      chk("b1_ready", s_if.b_ready, 1);

      // ---- Single master: 3 bursts of 4 beats from master0 ----
      @(negedge clk);
      idle();
      s_if.aw_ready = 1; s_if.w_ready = 1;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         k = (c == 0) ? 0 : c - 1;
         m0_if.aw_valid = (c < 3); m0_if.aw_id = 4'h3; m0_if.aw_len = 8'd3;
         m0_if.aw_addr = 32'h100 * (c + 1);
         m0_if.w_valid = 1; m0_if.w_data = 32'h1000 + k; m0_if.w_last = (k % 4 == 3);
         #1;
         if (c < 3) begin
            chk("single_aw_id", s_if.aw_id, 5'h03);
            chk("single_aw_addr", s_if.aw_addr, 32'h100 * (c + 1));
            chk("single_aw_len", s_if.aw_len, 8'd3);
         end
         if (c == 0) chk("no_bypass", s_if.w_valid, 0);
         else begin
            chk("single_w_valid", s_if.w_valid, 1);
            chk("single_w_data", s_if.w_data, 32'h1000 + k);
            chk("single_w_last", s_if.w_last, (k % 4 == 3));
         end
      end
      @(negedge clk);
      #1;
      chk("single_empty", s_if.w_valid, 0);
      @(negedge clk);
      m0_if.w_valid = 0;
      s_if.b_valid = 1; s_if.b_id = 5'h03; s_if.b_resp = 2'd0;
      m0_if.b_ready = 1; m1_if.b_ready = 1;
      #1;
      chk("b0_m0_valid", m0_if.b_valid, 1);
      chk("b0_m1_valid", m1_if.b_valid, 0);
      chk("b0_m0_id", m0_if.b_id, 4'h3);
      chk("b0_ready", s_if.b_ready, 1);

      // ---- Reads: both AR, R returned MSB 1 then MSB 0 ----
      @(negedge clk);
      idle();
      s_if.ar_ready = 1;
      m0_if.ar_valid = 1; m0_if.ar_id = 4'h1; m0_if.ar_addr = 32'h400;
      m1_if.ar_valid = 1; m1_if.ar_id = 4'h2; m1_if.ar_addr = 32'h500;
      #1;
      chk("ar0_id", s_if.ar_id, 5'h01);
      chk("ar0_addr", s_if.ar_addr, 32'h400);
      chk("ar0_m0_ready", m0_if.ar_ready, 1);
      chk("ar0_m1_ready", m1_if.ar_ready, 0);
      @(negedge clk);
      m0_if.ar_valid = 0;
      #1;
      chk("ar1_id", s_if.ar_id, 5'h12);
      chk("ar1_addr", s_if.ar_addr, 32'h500);
      chk("ar1_m1_ready", m1_if.ar_ready, 1);
      @(negedge clk);
      m1_if.ar_valid = 0;
      s_if.r_valid = 1; s_if.r_id = 5'h12; s_if.r_data = 32'hCAFE0001; s_if.r_last = 0;
      m0_if.r_ready = 1; m1_if.r_ready = 0;
      #1;
      chk("r1_m1_valid", m1_if.r_valid, 1);
      chk("r1_m0_valid", m0_if.r_valid, 0);
      chk("r1_m1_id", m1_if.r_id, 4'h2);
      chk("r1_m1_data", m1_if.r_data, 32'hCAFE0001);
      chk("r1_backpressure", s_if.r_ready, 0);
      @(negedge clk);
      m1_if.r_ready = 1; s_if.r_last = 1;
      #1;
      chk("r1_ready", s_if.r_ready, 1);
      chk("r1_last", m1_if.r_last, 1);
      @(negedge clk);
      s_if.r_id = 5'h01; s_if.r_data = 32'hBEEF0002;
      #1;
      chk("r0_m0_valid", m0_if.r_valid, 1);
      chk("r0_m1_valid", m1_if.r_valid, 0);
      chk("r0_m0_id", m0_if.r_id, 4'h1);
      chk("r0_m0_data", m0_if.r_data, 32'hBEEF0002);
      chk("r0_ready", s_if.r_ready, 1);

      // ---- Async reset in the middle of a W burst ----
      @(negedge clk);
      idle();
      s_if.aw_ready = 1; s_if.w_ready = 1;
      m0_if.aw_valid = 1; m0_if.aw_id = 4'h3; m0_if.aw_addr = 32'h700; m0_if.aw_len = 8'd3;
      #1;
      chk("mid_aw_valid", s_if.aw_valid, 1);
      @(negedge clk);
      m0_if.aw_valid = 0;
      m0_if.w_valid = 1; m0_if.w_data = 32'h2000; m0_if.w_last = 0;
      #1;
      chk("mid_w_live", s_if.w_valid, 1);
      @(negedge clk);
      m0_if.w_data = 32'h2001;
      m0_if.aw_valid = 1; m1_if.aw_valid = 1; m1_if.aw_id = 4'h2;
      m0_if.ar_valid = 1; m0_if.ar_id = 4'h1; m1_if.ar_valid = 1; m1_if.ar_id = 4'h2;
      #1;
      chk("pre_rst_grant", s_if.aw_id, 5'h12);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_w_valid", s_if.w_valid, 0);
      chk("arst_aw_valid", s_if.aw_valid, 0);
      chk("arst_ar_valid", s_if.ar_valid, 0);
      chk("arst_m0_aw_ready", m0_if.aw_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_aw_id", s_if.aw_id, 5'h03);
      chk("post_rst_m0_ready", m0_if.aw_ready, 1);
      chk("post_rst_m1_ready", m1_if.aw_ready, 0);
      chk("post_rst_ar_id", s_if.ar_id, 5'h01);
      chk("post_rst_fifo_empty", s_if.w_valid, 0);

      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/axi_arbiter2.md
Name: axi_arbiter2

Overview:
- Shares one downstream AXI slave port between two upstream AXI masters.
- Arbitrates AW and AR independently with round-robin.
- Steers W beats in AW-grant order and routes B/R responses back by an ID bit it appends.
- Sits between two masters (e.g. core and DMA) and a single interconnect or memory port.

Parameters:
- W_FIFO_DEPTH, 4: number of granted-but-not-completed write bursts tracked. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- master0  axi_channel.slave  iface  upstream requester 0
- master1  axi_channel.slave  iface  upstream requester 1
- slave  axi_channel.master  iface  shared downstream port

Behaviour:
- Static check ($fatal at elaboration) on any of these mismatches:
  - slave.ID_WIDTH != master0.ID_WIDTH + 1
  - master0 and master1 parameters not identical
  - ADDR, DATA or any USER width differs from slave
- ID rule:
  - slave.aw_id = {src, master.aw_id}; slave.ar_id = {src, master.ar_id}; src is 0 or 1.
  - Responses route by ID MSB, which is stripped going upstream.
- Registers:
  - aw_prio and ar_prio: 1 bit each, the favoured master.
  - aw_lock and ar_lock: grant held plus the locked source.
  - W source FIFO: W_FIFO_DEPTH x 1 bit, with read pointer, write pointer and count.
- Reset (async): prio=0, locks clear, FIFO empty.
- Outputs are combinational from these registers. After reset:
  - slave aw_valid, ar_valid and w_valid are 0.
  - All master b_valid and r_valid are 0 until the slave responds.
- AW arbitration:
  - When unlocked, if exactly one master asserts aw_valid it wins. If both assert, aw_prio's master wins.
  - Winner's AW fields drive slave; the loser sees aw_ready=0.
  - If slave.aw_valid && !slave.aw_ready, lock to the winner, so the offer stays stable as AXI requires. Lock clears on handshake.
  - On handshake: push src into W FIFO and set aw_prio = ~src.
  - When the FIFO is full, slave.aw_valid=0 and both aw_ready=0. This holds even if a pop occurs the same cycle (no push-through at full).
- W steering:
  - FIFO empty: slave.w_valid=0, both w_ready=0.
  - Otherwise head src selects the master. Its w_* fields drive slave and it receives slave.w_ready; the other master sees w_ready=0.
  - Pop on a slave W handshake with w_last=1.
  - No bypass: first W beat of a burst can transfer no earlier than the cycle after its AW handshake.
  - A master presenting W before its AW is granted simply waits.
- B routing:
  - masterN.b_valid = slave.b_valid && b_id MSB == N.
  - slave.b_ready = b_ready of the master selected by the MSB.
  - b_resp and b_user fan out to both masters; lower ID bits go to both.
- AR arbitration: identical to AW, using ar_prio and ar_lock. There is no FIFO and no full condition.
- R routing: as B, selected by r_id MSB. r_data, r_resp, r_last and r_user fan out to both masters.
- Simultaneous AW push and W-last pop when not full: count unchanged, both pointers advance.
- Pointer wrap: pointers are log2(W_FIFO_DEPTH) bits and wrap naturally. Full is count==W_FIFO_DEPTH.
- Reset mid-burst: all in-flight state is discarded. The environment must reset upstream and downstream together.
- No combinational path from any master valid to that same master's ready except through the slave ready path.

Test Plan:
- Single master: master0 issues 3 AW bursts (len 3) with W data.
  - Slave sees aw_id MSB=0.
  - W beats arrive in order.
  - B with id MSB 0 reaches only master0.
- Contention: both masters hold aw_valid for 4 handshakes. Grants alternate 0,1,0,1, and each W burst is steered to the matching source in grant order.
- Lock: slave holds aw_ready=0 for 3 cycles while master1 is granted, and master0 raises aw_valid meanwhile.
  - Slave AW fields stay stable from master1.
  - master1 completes first.
- FIFO full (depth 4): 4 AWs accepted with W withheld. The 5th AW is stalled (slave.aw_valid=0). After one W burst with last completes, the 5th is accepted the next cycle.
- Read interleave: both masters issue AR. The slave returns R beats with MSB 1 then MSB 0, each reaching only the correct master with the MSB stripped. r_ready backpressure from master1 stalls slave.r_ready.
- Async reset asserted mid W burst: immediately slave w_valid, aw_valid and ar_valid are 0 and the FIFO is empty. After release the first grant goes to master0.
